// File: rtl/if1_pc_predictor_pkg.sv
`default_nettype none
// ============================================================================
// Module : if1_pc_predictor_pkg
// Brief  : Shared constants, BTB write-op struct and counter helper for IF1
// Rev    : 1.0  initial release
// ============================================================================
package if1_pc_predictor_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;

    localparam logic [1:0] BP_SNT = 2'b00;
    localparam logic [1:0] BP_WNT = 2'b01;
    localparam logic [1:0] BP_WT  = 2'b10;
    localparam logic [1:0] BP_ST  = 2'b11;

    // One write-port transaction: a training op and an invalidate op that the
    // top has already arbitrated, so the two never target the same index.
    typedef struct packed {
        logic        train_en;
        logic [31:0] train_pc;
        logic        train_taken;
        logic [31:0] train_target;
        logic        inv_en;
        logic [31:0] inv_pc;
    } btb_wr_t;

    function automatic logic [1:0] bp_ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (ctr == BP_ST) ? BP_ST : ctr + 2'd1;
        end else begin
            nxt = (ctr == BP_SNT) ? BP_SNT : ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/if1_pc_predictor_btb_array.sv
`default_nettype none
// ============================================================================
// Module : if1_pc_predictor_btb_array
// Brief  : Direct-mapped BTB with 2-bit counters; 1 comb read, 1 write port
// Rev    : 1.0  initial release
// ============================================================================
module if1_pc_predictor_btb_array
    import if1_pc_predictor_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] rd_pc,
    output logic        rd_hit,
    output logic        rd_taken,
    output logic [31:0] rd_target,
    input  btb_wr_t     wr
);

    localparam int TAG_W = 32 - IDX_W - 2;

    logic              r_valid  [ENTRIES];
    logic [TAG_W-1:0]  r_tag    [ENTRIES];
    logic [29:0]       r_target [ENTRIES];
    logic [1:0]        r_ctr    [ENTRIES];

    logic [IDX_W-1:0]  w_rd_idx;
    logic [TAG_W-1:0]  w_rd_tag;
    logic [IDX_W-1:0]  w_tr_idx;
    logic [TAG_W-1:0]  w_tr_tag;
    logic              w_tr_hit;
    logic [IDX_W-1:0]  w_inv_idx;
    logic [TAG_W-1:0]  w_inv_tag;
    logic              w_inv_hit;
    logic              w_unused;

    assign w_rd_idx  = rd_pc[IDX_W+1:2];
    assign w_rd_tag  = rd_pc[31:IDX_W+2];
    assign w_tr_idx  = wr.train_pc[IDX_W+1:2];
    assign w_tr_tag  = wr.train_pc[31:IDX_W+2];
    assign w_inv_idx = wr.inv_pc[IDX_W+1:2];
    assign w_inv_tag = wr.inv_pc[31:IDX_W+2];

    assign w_tr_hit  = r_valid[w_tr_idx]  && (r_tag[w_tr_idx]  == w_tr_tag);
    assign w_inv_hit = r_valid[w_inv_idx] && (r_tag[w_inv_idx] == w_inv_tag);

    // Lookup always reflects pre-edge contents; no write-to-read bypass.
    assign rd_hit    = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
    assign rd_taken  = rd_hit && r_ctr[w_rd_idx][1];
    assign rd_target = rd_taken ? {r_target[w_rd_idx], 2'b00} : 32'h0;

    assign w_unused = ^{rd_pc[1:0], wr.train_pc[1:0], wr.train_target[1:0], wr.inv_pc[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= BP_SNT;
            end
        end else begin
            if (wr.inv_en && w_inv_hit) begin
                r_valid[w_inv_idx] <= 1'b0;
            end
            if (wr.train_en) begin
                if (w_tr_hit) begin
                    r_ctr[w_tr_idx] <= bp_ctr_next(r_ctr[w_tr_idx], wr.train_taken);
                    if (wr.train_taken) begin
                        r_target[w_tr_idx] <= wr.train_target[31:2];
                    end
                end else if (wr.train_taken) begin
                    r_valid[w_tr_idx]  <= 1'b1;
                    r_tag[w_tr_idx]    <= w_tr_tag;
                    r_target[w_tr_idx] <= wr.train_target[31:2];
                    r_ctr[w_tr_idx]    <= BP_WT;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/if1_pc_predictor.sv
`default_nettype none
// ============================================================================
// Module : if1_pc_predictor
// Brief  : IF1 fetch-PC register, next-PC mux and BTB train/invalidate arbiter
// Rev    : 1.0  initial release
// ============================================================================
module if1_pc_predictor
    import if1_pc_predictor_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int          BTB_ENTRIES = 16,
    parameter int          IDX_W       = $clog2(BTB_ENTRIES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_wen,
    input  logic        pc_is_wrong,
    input  logic [31:0] pc_correct,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        inv_valid,
    input  logic [31:0] inv_pc,
    output logic [31:0] if1_pc,
    output logic        if1_branch_bp,
    output logic [31:0] if1_bp_target
);

    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] w_pc_plus4;
    logic        w_rd_hit;
    logic        w_same_idx;
    btb_wr_t     w_wr;
    logic        w_unused;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_same_idx = (upd_pc[IDX_W+1:2] == inv_pc[IDX_W+1:2]);
    assign w_unused   = ^{pc_correct[1:0], w_rd_hit};

    // Training owns the index when both ops collide; otherwise both proceed.
    always_comb begin
        w_wr              = '0;
        w_wr.train_en     = upd_valid;
        w_wr.train_pc     = upd_pc;
        w_wr.train_taken  = upd_taken;
        w_wr.train_target = upd_target;
        w_wr.inv_en       = inv_valid && !(upd_valid && w_same_idx);
        w_wr.inv_pc       = inv_pc;
    end

    always_comb begin
        w_pc_next = r_pc;
        if (pc_is_wrong) begin
            w_pc_next = {pc_correct[31:2], 2'b00};
        end else if (pc_wen) begin
            w_pc_next = if1_branch_bp ? if1_bp_target : w_pc_plus4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    if1_pc_predictor_btb_array #(
        .ENTRIES (BTB_ENTRIES),
        .IDX_W   (IDX_W)
    ) u_btb (
        .clk       (clk),
        .rst       (rst),
        .rd_pc     (r_pc),
        .rd_hit    (w_rd_hit),
        .rd_taken  (if1_branch_bp),
        .rd_target (if1_bp_target),
        .wr        (w_wr)
    );

    assign if1_pc = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_if1_pc_predictor.sv
`default_nettype none
// ============================================================================
// Module : tb_if1_pc_predictor
// Brief  : Directed self-checking bench for the IF1 PC predictor
// Rev    : 1.0  initial release
// ============================================================================
module tb_if1_pc_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_wen;
    logic        pc_is_wrong;
    logic [31:0] pc_correct;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        inv_valid;
    logic [31:0] inv_pc;
    logic [31:0] if1_pc;
    logic        if1_branch_bp;
    logic [31:0] if1_bp_target;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    if1_pc_predictor dut (
        .clk           (clk),
        .rst           (rst),
        .pc_wen        (pc_wen),
        .pc_is_wrong   (pc_is_wrong),
        .pc_correct    (pc_correct),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_taken     (upd_taken),
        .upd_target    (upd_target),
        .inv_valid     (inv_valid),
        .inv_pc        (inv_pc),
        .if1_pc        (if1_pc),
        .if1_branch_bp (if1_branch_bp),
        .if1_bp_target (if1_bp_target)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_pulses();
        upd_valid   = 1'b0;
        inv_valid   = 1'b0;
        pc_is_wrong = 1'b0;
    endtask

    task automatic train(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_taken  = taken;
        upd_target = tgt;
    endtask

    task automatic redirect(input logic [31:0] pc);
        pc_is_wrong = 1'b1;
        pc_correct  = pc;
    endtask

    task automatic invalidate(input logic [31:0] pc);
        inv_valid = 1'b1;
        inv_pc    = pc;
    endtask

    initial begin
        rst = 1'b1; pc_wen = 1'b0; pc_is_wrong = 1'b0; pc_correct = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        inv_valid = 1'b0; inv_pc = '0;
        step(); step();
        check("rst_pc", if1_pc, 32'h1c000000);
        check("rst_bp", {31'd0, if1_branch_bp}, 32'd0);
        check("rst_tgt", if1_bp_target, 32'h0);

        // Reset release, sequential fetch
        rst = 1'b0; pc_wen = 1'b1;
        check("seq0", if1_pc, 32'h1c000000);
        step(); check("seq1", if1_pc, 32'h1c000004);
        step(); check("seq2", if1_pc, 32'h1c000008);
        check("seq_bp", {31'd0, if1_branch_bp}, 32'd0);

        // Allocate 1c000010 -> 1c000100 while stalled
        pc_wen = 1'b0; train(32'h1c000010, 1'b1, 32'h1c000100);
        step(); clear_pulses();
        check("stall_hold", if1_pc, 32'h1c000008);
        pc_wen = 1'b1;
        step(); check("pc_0c", if1_pc, 32'h1c00000c);
        check("bp_0c", {31'd0, if1_branch_bp}, 32'd0);
        step(); check("pc_10", if1_pc, 32'h1c000010);
        check("bp_10", {31'd0, if1_branch_bp}, 32'd1);
        check("tgt_10", if1_bp_target, 32'h1c000100);
        step(); check("pc_jump", if1_pc, 32'h1c000100);

        // Counter to 11, then two not-taken updates
        pc_wen = 1'b0; train(32'h1c000010, 1'b1, 32'h1c000100);
        step();
        train(32'h1c000010, 1'b0, 32'h0); redirect(32'h1c000010);
        step(); clear_pulses();
        check("nt1_pc", if1_pc, 32'h1c000010);
        check("nt1_bp", {31'd0, if1_branch_bp}, 32'd1);
        train(32'h1c000010, 1'b0, 32'h0);
        step(); clear_pulses();
        check("nt2_bp", {31'd0, if1_branch_bp}, 32'd0);
        check("nt2_tgt", if1_bp_target, 32'h0);
        pc_wen = 1'b1;
        step(); check("nt2_fall", if1_pc, 32'h1c000014);

        // Redirect overrides stall, low bits cleared; plain stall holds
        pc_wen = 1'b0; redirect(32'h1c000203);
        step(); clear_pulses();
        check("redir", if1_pc, 32'h1c000200);
        step(); check("hold1", if1_pc, 32'h1c000200);
        step(); check("hold2", if1_pc, 32'h1c000200);

        // Same index, different tag: train wins (ctr 01->10, new target)
        train(32'h1c000010, 1'b1, 32'h1c000300); invalidate(32'h1c000050);
        redirect(32'h1c000010);
        step(); clear_pulses();
        check("same_idx_bp", {31'd0, if1_branch_bp}, 32'd1);
        check("same_idx_tgt", if1_bp_target, 32'h1c000300);

        // Same index, same tag: invalidate still dropped (ctr -> 11)
        train(32'h1c000010, 1'b1, 32'h1c000300); invalidate(32'h1c000010);
        step(); clear_pulses();
        check("same_pc_bp", {31'd0, if1_branch_bp}, 32'd1);

        // Allocate second entry and observe it
        train(32'h1c000020, 1'b1, 32'h1c000400); redirect(32'h1c000020);
        step(); clear_pulses();
        check("e2_bp", {31'd0, if1_branch_bp}, 32'd1);
        check("e2_tgt", if1_bp_target, 32'h1c000400);

        // Different indices: both apply; stalled PC re-predicts
        train(32'h1c000010, 1'b0, 32'h0); invalidate(32'h1c000020);
        step(); clear_pulses();
        check("e2_inv_bp", {31'd0, if1_branch_bp}, 32'd0);
        check("e2_inv_pc", if1_pc, 32'h1c000020);
        redirect(32'h1c000010);
        step(); clear_pulses();
        check("e1_ctr10_bp", {31'd0, if1_branch_bp}, 32'd1);

        // Tag-mismatched invalidate is ignored; matching one clears
        invalidate(32'h1c000050);
        step(); clear_pulses();
        check("inv_miss_bp", {31'd0, if1_branch_bp}, 32'd1);
        invalidate(32'h1c000010);
        step(); clear_pulses();
        check("inv_hit_bp", {31'd0, if1_branch_bp}, 32'd0);

        // Not-taken miss allocates nothing
        train(32'h1c000030, 1'b0, 32'h1c000500); redirect(32'h1c000030);
        step(); clear_pulses();
        check("nt_miss_bp", {31'd0, if1_branch_bp}, 32'd0);

        // PC+4 wrap
        pc_wen = 1'b1; redirect(32'hfffffffc);
        step(); clear_pulses();
        check("wrap_pre", if1_pc, 32'hfffffffc);
        step(); check("wrap", if1_pc, 32'h00000000);

        // Retrain then reset mid-cycle with pending update and redirect
        pc_wen = 1'b0; train(32'h1c000010, 1'b1, 32'h1c000100); redirect(32'h1c000010);
        step(); clear_pulses();
        check("pre_rst_bp", {31'd0, if1_branch_bp}, 32'd1);
        train(32'h1c000040, 1'b1, 32'h1c000600); redirect(32'h1c000040);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_pc", if1_pc, 32'h1c000000);
        check("mid_rst_bp", {31'd0, if1_branch_bp}, 32'd0);
        step(); clear_pulses();
        check("rst_hold_pc", if1_pc, 32'h1c000000);
        rst = 1'b0; redirect(32'h1c000010);
        step(); clear_pulses();
        check("post_rst_pc", if1_pc, 32'h1c000010);
        check("post_rst_bp", {31'd0, if1_branch_bp}, 32'd0);
        redirect(32'h1c000040);
        step(); clear_pulses();
        check("post_rst_pend", {31'd0, if1_branch_bp}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
